// File: rtl/mole_spawner_if.sv
// mole_spawner_if
//   Bundles the game-side controls, hit requests and round results of the
//   mole spawner.
//   Ports (as signals):
//     i_enable, i_level, i_skip        game control (driven by master)
//     i_hit_valid, i_hit_hole          player press (driven by master)
//     o_mole_mask                      holes with a mole up (driven by slave)
//     o_spawned, o_hit, o_wrong,       single-cycle result pulses (slave)
//     o_round_done
//     o_miss_count                     moles left unhit, valid with o_round_done
//   master: button/debounce + display/score side; slave: the spawner.
interface mole_spawner_if #(
  parameter int NUM_HOLES = 5,
  parameter int MAX_MOLES = 2
);
  localparam int HOLE_W = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;
  localparam int CNT_W  = $clog2(MAX_MOLES + 1);

  logic                 i_enable;
  logic [1:0]           i_level;
  logic                 i_skip;
  logic                 i_hit_valid;
  logic [HOLE_W-1:0]    i_hit_hole;
  logic [NUM_HOLES-1:0] o_mole_mask;
  logic                 o_spawned;
  logic                 o_hit;
  logic                 o_wrong;
  logic                 o_round_done;
  logic [CNT_W-1:0]     o_miss_count;

  modport master (
    output i_enable, i_level, i_skip, i_hit_valid, i_hit_hole,
    input  o_mole_mask, o_spawned, o_hit, o_wrong, o_round_done, o_miss_count
  );

  modport slave (
    input  i_enable, i_level, i_skip, i_hit_valid, i_hit_hole,
    output o_mole_mask, o_spawned, o_hit, o_wrong, o_round_done, o_miss_count
  );
endinterface

// File: rtl/mole_spawner.sv
// mole_spawner
//   Each round raises up to MAX_MOLES moles on distinct holes (chosen by a
//   16-bit Galois LFSR, poly mask 16'hB400), holds them for CUTOFF >> level
//   clocks, and reports hits, wrong-hole presses and misses.
//   Ports:
//     i_clk   system clock
//     i_rst   synchronous, active-high reset
//     bus     mole_spawner_if.slave: enable/level/skip, hit requests,
//             mole mask and registered result pulses / miss count
module mole_spawner #(
  parameter int          NUM_HOLES = 5,
  parameter int          MAX_MOLES = 2,
  parameter int          CUTOFF    = 1000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic           i_clk,
  input logic           i_rst,
  mole_spawner_if.slave bus
);
  localparam int          HOLE_W  = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;
  localparam int          CNT_W   = $clog2(MAX_MOLES + 1);
  localparam int          DW      = $clog2(CUTOFF + 1);
  localparam logic [15:0] HOLES16 = 16'(NUM_HOLES);

  typedef enum logic [1:0] {IDLE, PICK, UP, CLEAR} state_t;

  state_t               state;
  logic [15:0]          lfsr;
  logic [NUM_HOLES-1:0] mask;
  logic [CNT_W-1:0]     k_r;
  logic [CNT_W-1:0]     placed;
  logic [2:0]           retry;
  logic [DW-1:0]        dwell_r;
  logic [DW-1:0]        cnt;
  logic                 spawned_r, hit_r, wrong_r, done_r;
  logic [CNT_W-1:0]     miss_r;

  logic [15:0]          lfsr_next;
  logic [HOLE_W-1:0]    cand;
  logic [NUM_HOLES-1:0] cand_oh, free_oh, pick_oh, hit_sel, mask_hit;
  logic                 do_place, hit_ok;
  logic [2:0]           lvl_p1;
  logic [CNT_W-1:0]     k_start, placed_inc;
  logic [DW-1:0]        dwell_start;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_HOLES-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_HOLES; i++) c = c + CNT_W'(m[i]);
    return c;
  endfunction

  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]};
    if (lfsr[0]) lfsr_next = lfsr_next ^ 16'hB400;

    cand    = HOLE_W'(lfsr % HOLES16);
    cand_oh = NUM_HOLES'(1) << cand;
    // Lowest clear bit of mask as a one-hot vector.
    free_oh = ~mask & (mask + NUM_HOLES'(1));

    do_place = 1'b0;
    pick_oh  = '0;
    if (retry == 3'd4) begin
      do_place = 1'b1;
      pick_oh  = free_oh;
    end else if ((mask & cand_oh) == '0) begin
      do_place = 1'b1;
      pick_oh  = cand_oh;
    end
    placed_inc = placed + CNT_W'(1);

    // Holes >= NUM_HOLES shift out of the select, so they read as empty
    // and fall through to the wrong-hole path.
    hit_sel  = NUM_HOLES'(1) << bus.i_hit_hole;
    hit_ok   = bus.i_hit_valid && ((mask & hit_sel) != '0);
    mask_hit = hit_ok ? (mask & ~hit_sel) : mask;

    lvl_p1      = {1'b0, bus.i_level} + 3'd1;
    k_start     = (int'(lvl_p1) >= MAX_MOLES) ? CNT_W'(MAX_MOLES) : CNT_W'(lvl_p1);
    dwell_start = DW'(CUTOFF) >> bus.i_level;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      lfsr      <= LFSR_SEED;
      mask      <= '0;
      k_r       <= '0;
      placed    <= '0;
      retry     <= '0;
      dwell_r   <= '0;
      cnt       <= '0;
      spawned_r <= 1'b0;
      hit_r     <= 1'b0;
      wrong_r   <= 1'b0;
      done_r    <= 1'b0;
      miss_r    <= '0;
    end else begin
      lfsr      <= lfsr_next;
      spawned_r <= 1'b0;
      hit_r     <= 1'b0;
      wrong_r   <= 1'b0;
      done_r    <= 1'b0;
      if (!bus.i_enable) begin
        state <= IDLE;
        mask  <= '0;
      end else begin
        unique case (state)
          IDLE, CLEAR: begin
            state   <= PICK;
            mask    <= '0;
            k_r     <= k_start;
            dwell_r <= dwell_start;
            placed  <= '0;
            retry   <= '0;
          end
          PICK: begin
            if (bus.i_skip) begin
              state  <= CLEAR;
              mask   <= '0;
              done_r <= 1'b1;
              miss_r <= '0;
            end else if (do_place) begin
              mask   <= mask | pick_oh;
              placed <= placed_inc;
              retry  <= '0;
              if (placed_inc == k_r) begin
                spawned_r <= 1'b1;
                cnt       <= dwell_r - DW'(1);
                state     <= UP;
              end
            end else begin
              retry <= retry + 3'd1;
            end
          end
          UP: begin
            hit_r   <= hit_ok;
            wrong_r <= bus.i_hit_valid && !hit_ok;
            // Hit is applied first; skip, last-mole hit or expiry then
            // close the round with the post-hit mask.
            if (bus.i_skip || (hit_ok && mask_hit == '0) || cnt == '0) begin
              state  <= CLEAR;
              mask   <= '0;
              done_r <= 1'b1;
              miss_r <= bus.i_skip ? '0 : popcount(mask_hit);
            end else begin
              mask <= mask_hit;
              cnt  <= cnt - DW'(1);
            end
          end
          default: begin
            state <= IDLE;
            mask  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.o_mole_mask  = mask;
  assign bus.o_spawned    = spawned_r;
  assign bus.o_hit        = hit_r;
  assign bus.o_wrong      = wrong_r;
  assign bus.o_round_done = done_r;
  assign bus.o_miss_count = miss_r;
endmodule

// File: tb/tb_mole_spawner.sv
// tb_mole_spawner
//   Directed and randomized checks of mole_spawner. Instance A: 5 holes,
//   2 moles; instance B: 3 holes, 3 moles. The reference model tracks the
//   moles that are up, elapsed dwell, and the expected result of every press.
module tb_mole_spawner;
  localparam int NA  = 5;
  localparam int MA  = 2;
  localparam int NB  = 3;
  localparam int MB  = 3;
  localparam int CUT = 1000;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  mole_spawner_if #(.NUM_HOLES(NA), .MAX_MOLES(MA)) a ();
  mole_spawner_if #(.NUM_HOLES(NB), .MAX_MOLES(MB)) b ();

  mole_spawner #(.NUM_HOLES(NA), .MAX_MOLES(MA), .CUTOFF(CUT), .LFSR_SEED(16'hACE1))
    dut_a (.i_clk(clk), .i_rst(rst_a), .bus(a));
  mole_spawner #(.NUM_HOLES(NB), .MAX_MOLES(MB), .CUTOFF(CUT), .LFSR_SEED(16'hACE1))
    dut_b (.i_clk(clk), .i_rst(rst_b), .bus(b));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state for instance A
  logic [NA-1:0] m_mask;
  int            m_k, m_dwell, m_e, m_lvl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_hole(input logic [NA-1:0] m, input bit want_set);
    int idx[$];
    for (int i = 0; i < NA; i++) if (m[i] == want_set) idx.push_back(i);
    return idx[$urandom_range(0, idx.size() - 1)];
  endfunction

  // Wait for o_spawned on A, then load the model for the new round.
  task automatic wait_spawn_a(input int max_lat);
    int t;
    t = 0;
    do begin
      tick();
      t++;
    end while (!a.o_spawned && t < 200);
    chk("spawn_seen", 32'(a.o_spawned), 1);
    chk("spawn_latency_ok", 32'(t <= max_lat), 1);
    m_k     = (m_lvl + 1 < MA) ? m_lvl + 1 : MA;
    m_dwell = CUT / (2 ** m_lvl);
    m_e     = 0;
    chk("spawn_popcount", $countones(a.o_mole_mask), m_k);
    m_mask  = a.o_mole_mask;
  endtask

  // One UP-state cycle on A with optional press/skip, checked against the model.
  task automatic up_step(input bit hv, input int h, input bit sk, output bit done);
    bit eh, ew;
    int emiss;
    eh = 1'b0;
    ew = 1'b0;
    a.i_hit_valid = hv;
    a.i_hit_hole  = 3'(h);
    a.i_skip      = sk;
    if (hv) begin
      if (h < NA && m_mask[h]) begin
        eh = 1'b1;
        m_mask[h] = 1'b0;
      end else begin
        ew = 1'b1;
      end
    end
    done  = sk || (eh && m_mask == '0) || (m_e == m_dwell - 1);
    emiss = sk ? 0 : $countones(m_mask);
    tick();
    m_e++;
    a.i_hit_valid = 1'b0;
    a.i_skip      = 1'b0;
    chk("up_hit", 32'(a.o_hit), 32'(eh));
    chk("up_wrong", 32'(a.o_wrong), 32'(ew));
    chk("up_round_done", 32'(a.o_round_done), 32'(done));
    chk("up_spawned", 32'(a.o_spawned), 0);
    if (done) begin
      m_mask = '0;
      chk("up_miss", 32'(a.o_miss_count), 32'(emiss));
    end
    chk("up_mask", 32'(a.o_mole_mask), 32'(m_mask));
  endtask

  task automatic run_idle_until_done(input int budget);
    bit d;
    int n;
    d = 1'b0;
    n = 0;
    while (!d && n < budget) begin
      up_step(1'b0, 0, 1'b0, d);
      n++;
    end
    chk("round_end_seen", 32'(d), 1);
  endtask

  initial begin
    bit d;
    int h, t, n;
    a.i_enable = 1'b0; a.i_level = '0; a.i_skip = 1'b0; a.i_hit_valid = 1'b0; a.i_hit_hole = '0;
    b.i_enable = 1'b0; b.i_level = '0; b.i_skip = 1'b0; b.i_hit_valid = 1'b0; b.i_hit_hole = '0;

    // Reset held 3 cycles
    repeat (3) tick();
    chk("rst_mask", 32'(a.o_mole_mask), 0);
    chk("rst_spawned", 32'(a.o_spawned), 0);
    chk("rst_hit", 32'(a.o_hit), 0);
    chk("rst_wrong", 32'(a.o_wrong), 0);
    chk("rst_done", 32'(a.o_round_done), 0);
    chk("rst_miss", 32'(a.o_miss_count), 0);
    chk("rst_b_mask", 32'(b.o_mole_mask), 0);
    rst_a = 1'b0;

    // Disabled: stays idle, presses ignored
    a.i_hit_valid = 1'b1; a.i_hit_hole = 3'd1;
    tick();
    a.i_hit_valid = 1'b0;
    repeat (2) tick();
    chk("idle_mask", 32'(a.o_mole_mask), 0);
    chk("idle_hit", 32'(a.o_hit | a.o_wrong), 0);

    // Level 0: one mole, full dwell, one miss
    m_lvl = 0; a.i_level = 2'd0; a.i_enable = 1'b1;
    wait_spawn_a(3);
    run_idle_until_done(CUT + 10);
    chk("dwell_l0", 32'(m_e), 1000);
    chk("miss_l0", 32'(a.o_miss_count), 1);
    m_lvl = 1; a.i_level = 2'd1;
    tick();
    chk("miss_hold", 32'(a.o_miss_count), 1);
    chk("done_one_cycle", 32'(a.o_round_done), 0);

    // Level 1: hit both moles
    wait_spawn_a(8);
    repeat ($urandom_range(0, 20)) up_step(1'b0, 0, 1'b0, d);
    up_step(1'b1, pick_hole(m_mask, 1'b1), 1'b0, d);
    chk("first_hit_not_done", 32'(d), 0);
    repeat ($urandom_range(0, 20)) up_step(1'b0, 0, 1'b0, d);
    up_step(1'b1, pick_hole(m_mask, 1'b1), 1'b0, d);
    chk("second_hit_done", 32'(a.o_round_done), 1);
    chk("second_hit_miss0", 32'(a.o_miss_count), 0);

    // Wrong presses, then a hit on the expiry cycle
    wait_spawn_a(8);
    up_step(1'b1, pick_hole(m_mask, 1'b0), 1'b0, d);
    up_step(1'b1, 7, 1'b0, d);
    up_step(1'b1, $urandom_range(5, 7), 1'b0, d);
    chk("wrong_mask_kept", $countones(a.o_mole_mask), 2);
    while (m_e < m_dwell - 1) up_step(1'b0, 0, 1'b0, d);
    up_step(1'b1, pick_hole(m_mask, 1'b1), 1'b0, d);
    chk("expiry_hit", 32'(a.o_hit), 1);
    chk("expiry_miss", 32'(a.o_miss_count), 1);
    m_lvl = 0; a.i_level = 2'd0;

    // Drop enable during UP
    wait_spawn_a(3);
    repeat (3) up_step(1'b0, 0, 1'b0, d);
    a.i_enable = 1'b0;
    tick();
    chk("dis_mask", 32'(a.o_mole_mask), 0);
    chk("dis_done", 32'(a.o_round_done), 0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      a.i_hit_valid = 1'b1; a.i_hit_hole = 3'($urandom_range(0, 4));
      tick();
      n += int'(a.o_round_done) + int'(a.o_hit) + int'(a.o_wrong) + int'(a.o_spawned)
           + $countones(a.o_mole_mask);
    end
    a.i_hit_valid = 1'b0;
    chk("dis_quiet", 32'(n), 0);
    chk("dis_miss_hold", 32'(a.o_miss_count), 1);

    // Skip alone, then hit together with skip
    m_lvl = 2; a.i_level = 2'd2; a.i_enable = 1'b1;
    wait_spawn_a(8);
    repeat ($urandom_range(1, 10)) up_step(1'b0, 0, 1'b0, d);
    up_step(1'b0, 0, 1'b1, d);
    chk("skip_miss0", 32'(a.o_miss_count), 0);
    wait_spawn_a(8);
    up_step(1'b1, pick_hole(m_mask, 1'b1), 1'b1, d);
    chk("hit_skip_hit", 32'(a.o_hit), 1);
    chk("hit_skip_done", 32'(a.o_round_done), 1);

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      m_lvl = $urandom_range(1, 3); a.i_level = 2'(m_lvl);
      wait_spawn_a(8);
      d = 1'b0;
      n = 0;
      while (!d && n < CUT + 10) begin
        if ($urandom_range(0, 3) == 0) begin
          h = ($urandom_range(0, 1) == 0) ? pick_hole(m_mask, 1'b1) : $urandom_range(0, 7);
          up_step(1'b1, h, ($urandom_range(0, 199) == 0), d);
        end else begin
          up_step(1'b0, 0, ($urandom_range(0, 199) == 0), d);
        end
        n++;
      end
      chk("rand_round_end", 32'(d), 1);
    end
    a.i_enable = 1'b0;

    // Instance B: 3 holes, 3 moles, level 3
    rst_b = 1'b0;
    b.i_level = 2'd3; b.i_enable = 1'b1;
    for (int r = 0; r < 2; r++) begin
      t = 0;
      do begin
        tick();
        t++;
      end while (!b.o_spawned && t < 40);
      chk("b_spawn_seen", 32'(b.o_spawned), 1);
      chk("b_pick_le15", 32'(t <= 16), 1);
      chk("b_mask_full", 32'(b.o_mole_mask), 32'h7);
      n = 0;
      do begin
        tick();
        n++;
      end while (!b.o_round_done && n < 200);
      chk("b_dwell125", 32'(n), 125);
      chk("b_miss3", 32'(b.o_miss_count), 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
